// File: rtl/dcache_store_buffer.sv
// In-order store buffer between writeback and the dcache write port, with a load-overlap check.
// Optional STORE_FWD_CHECK_EN: per-entry 8-byte block compare; otherwise any pending store blocks loads.
module dcache_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [1:0]               st_size,
  output logic                     wr_req_valid,
  input  logic                     wr_req_ready,
  output logic [ADDR_W-1:0]        wr_req_address,
  output logic [DATA_W-1:0]        wr_req_data,
  output logic [1:0]               wr_size_out,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [1:0]               ld_size,
  output logic                     ld_conflict,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // st_ready depends only on registered count, never on wr_req_ready
  assign st_ready       = (count_q != CNT_W'(DEPTH));
  assign wr_req_valid   = (count_q != '0);
  assign sb_empty       = (count_q == '0);
  assign sb_count       = count_q;
  assign wr_req_address = addr_q[head_q];
  assign wr_req_data    = data_q[head_q];
  assign wr_size_out    = size_q[head_q];

  assign push = st_valid & st_ready;
  assign pop  = wr_req_valid & wr_req_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)  valid_q[head_q] <= 1'b0;
      if (push) valid_q[tail_q] <= 1'b1;
    end
  end

  // Payload storage needs no reset; the valid bits and count qualify it
  always_ff @(posedge clk) begin
    if (reset && push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      size_q[tail_q] <= st_size;
    end
  end

`ifdef STORE_FWD_CHECK_EN
  localparam int unsigned BLK_W = ADDR_W - 3;

  function automatic logic crosses(input logic [2:0] off, input logic [1:0] size);
    logic [3:0] last;
    last = {1'b0, off} + (4'd1 << size);
    return last > 4'd8;
  endfunction

  // Block sets are {blk} or {blk, blk+1}; blk+1 wraps at the top of the address space
  function automatic logic overlap(input logic [ADDR_W-1:0] sa, input logic [1:0] ss,
                                   input logic [ADDR_W-1:0] la, input logic [1:0] ls);
    logic [BLK_W-1:0] sb, lb;
    logic             sc, lc;
    sb = sa[ADDR_W-1:3];
    lb = la[ADDR_W-1:3];
    sc = crosses(sa[2:0], ss);
    lc = crosses(la[2:0], ls);
    return (sb == lb) || (sc && ((sb + BLK_W'(1)) == lb)) || (lc && (sb == (lb + BLK_W'(1))));
  endfunction

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && overlap(addr_q[i], size_q[i], ld_addr, ld_size)) ld_conflict = 1'b1;
    end
  end
`else
  logic unused_ld;
  assign unused_ld   = ^{ld_addr, ld_size, valid_q};
  assign ld_conflict = ~sb_empty;
`endif

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed, table-driven bench for dcache_store_buffer plus hand sequences for reset,
// pointer wrap, overlap boundaries and reset mid-drain.
module tb_dcache_store_buffer;

  localparam int unsigned DEPTH = 4;

`ifdef STORE_FWD_CHECK_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [31:0] wr_req_address;
  logic [63:0] wr_req_data;
  logic [1:0]  wr_size_out;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_conflict;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int tests  = 0;
  int failed = 0;

  dcache_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_size        (st_size),
    .wr_req_valid   (wr_req_valid),
    .wr_req_ready   (wr_req_ready),
    .wr_req_address (wr_req_address),
    .wr_req_data    (wr_req_data),
    .wr_size_out    (wr_size_out),
    .ld_addr        (ld_addr),
    .ld_size        (ld_size),
    .ld_conflict    (ld_conflict),
    .sb_empty       (sb_empty),
    .sb_count       (sb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  sz;
    logic        r;
    logic [31:0] la;
    logic [1:0]  lsz;
    logic        e_rdy;
    logic        e_wv;
    logic [31:0] e_a;
    logic [63:0] e_d;
    logic [1:0]  e_sz;
    logic [2:0]  e_cnt;
    logic        e_cf;   // expected conflict with block compare enabled
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    st_valid     = 1'b0;
    wr_req_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic check_ld(input string name, input logic [31:0] la, input logic [1:0] ls,
                          input logic exp_fwd);
    ld_addr = la;
    ld_size = ls;
    #1;
    check(name, ld_conflict, FWD ? exp_fwd : !sb_empty);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] q[$];
    int          sent;
    int          cyc;
    logic        can_push;

    vecs[0]  = '{1'b1, 32'h1000, 64'hAABB, 2'd2, 1'b0, 32'h1000, 2'd0,
                 1'b1, 1'b0, 32'h0, 64'h0, 2'd0, 3'd0, 1'b0};
    for (int i = 1; i <= 5; i++)
      vecs[i] = '{1'b0, 32'h0, 64'h0, 2'd0, 1'b0, 32'h1000, 2'd0,
                  1'b1, 1'b1, 32'h1000, 64'hAABB, 2'd2, 3'd1, 1'b1};
    vecs[6]  = '{1'b0, 32'h0, 64'h0, 2'd0, 1'b1, 32'h1000, 2'd0,
                 1'b1, 1'b1, 32'h1000, 64'hAABB, 2'd2, 3'd1, 1'b1};
    vecs[7]  = '{1'b0, 32'h0, 64'h0, 2'd0, 1'b0, 32'h1000, 2'd0,
                 1'b1, 1'b0, 32'h0, 64'h0, 2'd0, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 32'h100, 64'h1, 2'd3, 1'b0, 32'h0, 2'd0,
                 1'b1, 1'b0, 32'h0, 64'h0, 2'd0, 3'd0, 1'b0};
    vecs[9]  = '{1'b1, 32'h108, 64'h2, 2'd3, 1'b0, 32'h0, 2'd0,
                 1'b1, 1'b1, 32'h100, 64'h1, 2'd3, 3'd1, 1'b0};
    vecs[10] = '{1'b1, 32'h110, 64'h3, 2'd3, 1'b0, 32'h0, 2'd0,
                 1'b1, 1'b1, 32'h100, 64'h1, 2'd3, 3'd2, 1'b0};
    vecs[11] = '{1'b1, 32'h118, 64'h4, 2'd3, 1'b0, 32'h0, 2'd0,
                 1'b1, 1'b1, 32'h100, 64'h1, 2'd3, 3'd3, 1'b0};
    vecs[12] = '{1'b1, 32'h120, 64'h5, 2'd3, 1'b0, 32'h0, 2'd0,
                 1'b0, 1'b1, 32'h100, 64'h1, 2'd3, 3'd4, 1'b0};
    // Full with a dequeue in the same cycle: the store is still refused
    vecs[13] = '{1'b1, 32'h120, 64'h5, 2'd3, 1'b1, 32'h0, 2'd0,
                 1'b0, 1'b1, 32'h100, 64'h1, 2'd3, 3'd4, 1'b0};
    vecs[14] = '{1'b1, 32'h128, 64'h6, 2'd3, 1'b1, 32'h0, 2'd0,
                 1'b1, 1'b1, 32'h108, 64'h2, 2'd3, 3'd3, 1'b0};
    vecs[15] = '{1'b0, 32'h0, 64'h0, 2'd0, 1'b1, 32'h0, 2'd0,
                 1'b1, 1'b1, 32'h110, 64'h3, 2'd3, 3'd3, 1'b0};
    vecs[16] = '{1'b0, 32'h0, 64'h0, 2'd0, 1'b1, 32'h0, 2'd0,
                 1'b1, 1'b1, 32'h118, 64'h4, 2'd3, 3'd2, 1'b0};
    vecs[17] = '{1'b0, 32'h0, 64'h0, 2'd0, 1'b1, 32'h0, 2'd0,
                 1'b1, 1'b1, 32'h128, 64'h6, 2'd3, 3'd1, 1'b0};
    vecs[18] = '{1'b0, 32'h0, 64'h0, 2'd0, 1'b0, 32'h0, 2'd0,
                 1'b1, 1'b0, 32'h0, 64'h0, 2'd0, 3'd0, 1'b0};

    // Reset held two cycles with a store offered
    reset        = 1'b0;
    st_valid     = 1'b1;
    st_addr      = 32'h1000;
    st_data      = 64'h1234;
    st_size      = 2'd3;
    wr_req_ready = 1'b0;
    ld_addr      = 32'h1000;
    ld_size      = 2'd0;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_wr_valid", wr_req_valid, 1'b0);
    check("rst_count", sb_count, 3'd0);
    check("rst_empty", sb_empty, 1'b1);
    check("rst_conflict", ld_conflict, 1'b0);
    @(posedge clk); #1;
    reset    = 1'b1;
    st_valid = 1'b0;
    @(negedge clk);
    check("rst_no_entry_valid", wr_req_valid, 1'b0);
    check("rst_no_entry_count", sb_count, 3'd0);
    @(posedge clk); #1;

    // Table: single store hold/drain, fill to full, refused store, drain in order
    do_reset();
    for (int i = 0; i < 19; i++) begin
      st_valid     = vecs[i].v;
      st_addr      = vecs[i].a;
      st_data      = vecs[i].d;
      st_size      = vecs[i].sz;
      wr_req_ready = vecs[i].r;
      ld_addr      = vecs[i].la;
      ld_size      = vecs[i].lsz;
      @(negedge clk);
      check($sformatf("v%0d_st_ready", i), st_ready, vecs[i].e_rdy);
      check($sformatf("v%0d_wr_valid", i), wr_req_valid, vecs[i].e_wv);
      check($sformatf("v%0d_count", i), sb_count, vecs[i].e_cnt);
      check($sformatf("v%0d_empty", i), sb_empty, vecs[i].e_cnt == 3'd0);
      check($sformatf("v%0d_conflict", i), ld_conflict,
            FWD ? vecs[i].e_cf : (vecs[i].e_cnt != 3'd0));
      if (vecs[i].e_wv) begin
        check($sformatf("v%0d_addr", i), wr_req_address, vecs[i].e_a);
        check($sformatf("v%0d_data", i), wr_req_data, vecs[i].e_d);
        check($sformatf("v%0d_size", i), wr_size_out, vecs[i].e_sz);
      end
      @(posedge clk); #1;
    end
    st_valid     = 1'b0;
    wr_req_ready = 1'b0;

    // Pointer wrap: 10 stores, ready toggling every cycle, queue model
    do_reset();
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || q.size() != 0) && cyc < 200) begin
      st_valid     = (sent < 10);
      st_addr      = 32'h3000 + 32'(sent * 8);
      st_data      = 64'h500 + 64'(sent);
      st_size      = 2'd3;
      wr_req_ready = (cyc % 2) == 1;
      @(negedge clk);
      can_push = q.size() < DEPTH;
      check("wrap_count", sb_count, 64'(q.size()));
      check("wrap_max", sb_count <= 3'(DEPTH), 1'b1);
      check("wrap_st_ready", st_ready, can_push);
      check("wrap_wr_valid", wr_req_valid, q.size() != 0);
      if (q.size() != 0 && wr_req_ready) begin
        check("wrap_order", wr_req_data, q[0]);
        void'(q.pop_front());
      end
      if (st_valid && can_push) begin
        q.push_back(st_data);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("wrap_finished", cyc < 200, 1'b1);
    check("wrap_sent", 64'(sent), 64'd10);
    st_valid     = 1'b0;
    wr_req_ready = 1'b0;

    // Overlap: store 0x2006 4B covers blocks 0x400 and 0x401
    do_reset();
    store(32'h2006, 64'h77, 2'd2);
    @(negedge clk);
    check_ld("cf_cross_next", 32'h2008, 2'd0, 1'b1);
    check_ld("cf_far", 32'h2010, 2'd3, 1'b0);
    check_ld("cf_same_blk", 32'h2000, 2'd0, 1'b1);
    check_ld("cf_prev_blk", 32'h1FF8, 2'd3, 1'b0);
    check_ld("cf_ld_crosses_in", 32'h1FFC, 2'd3, 1'b1);
    @(posedge clk); #1;

    // Top-of-memory store crossing wraps into block 0
    do_reset();
    store(32'hFFFF_FFFC, 64'h1, 2'd3);
    @(negedge clk);
    check_ld("cf_wrap_blk0", 32'h0000_0004, 2'd0, 1'b1);
    check_ld("cf_wrap_blk1", 32'h0000_0008, 2'd0, 1'b0);
    @(posedge clk); #1;

    // Reset mid-drain with 3 entries and a store mid-handshake
    do_reset();
    store(32'h3000, 64'hA0, 2'd3);
    store(32'h3008, 64'hA1, 2'd3);
    store(32'h3010, 64'hA2, 2'd3);
    ld_addr = 32'h3008;
    ld_size = 2'd0;
    @(negedge clk);
    check("mid_pre_count", sb_count, 3'd3);
    check("mid_pre_valid", wr_req_valid, 1'b1);
    check("mid_pre_conflict", ld_conflict, 1'b1);
    reset        = 1'b0;
    st_valid     = 1'b1;
    st_addr      = 32'h3018;
    st_data      = 64'hA3;
    wr_req_ready = 1'b1;
    @(posedge clk); #1;
    reset        = 1'b1;
    st_valid     = 1'b0;
    wr_req_ready = 1'b0;
    @(negedge clk);
    check("mid_wr_valid", wr_req_valid, 1'b0);
    check("mid_count", sb_count, 3'd0);
    check("mid_conflict", ld_conflict, 1'b0);
    check("mid_empty", sb_empty, 1'b1);
    check("mid_st_ready", st_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
